// File: rtl/tx_arb_pkg.sv
// rtl/tx_arb_pkg.sv - shared types, source indices and index helpers for the TX line arbiter
package tx_arb_pkg;

   typedef enum logic [1:0] {
      OWN_NONE = 2'b00,
      OWN_TAPE = 2'b01,
      OWN_MIDI = 2'b10,
      OWN_UART = 2'b11
   } owner_t;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_OWN  = 1'b1
   } state_t;

   localparam int NUM_SRC = 3;

   localparam logic [1:0] SRC_TAPE = 2'd0;
   localparam logic [1:0] SRC_MIDI = 2'd1;
   localparam logic [1:0] SRC_UART = 2'd2;

   // Owner codes are source index + 1, so 00 stays free for "no owner".
   function automatic owner_t owner_of(input logic [1:0] idx);
      return owner_t'(idx + 2'd1);
   endfunction

   function automatic logic [1:0] src_of(input owner_t o);
      return 2'(o) - 2'd1;
   endfunction

endpackage

// File: rtl/tx_line_arbiter_if.sv
// rtl/tx_line_arbiter_if.sv - source levels, enables and arbitrated line/status bundle
interface tx_line_arbiter_if
   import tx_arb_pkg::*;
#(
   parameter int DROP_W = 8
);
   logic [NUM_SRC-1:0]        src_en;
   logic                      tape_out;
   logic                      midi_out;
   logic                      uart_out;
   logic                      drop_clr;
   logic                      uart_tx;
   logic [1:0]                owner;
   logic                      busy;
   logic [NUM_SRC*DROP_W-1:0] drop_cnt;

   modport master (
      output src_en, tape_out, midi_out, uart_out, drop_clr,
      input  uart_tx, owner, busy, drop_cnt
   );

   modport slave (
      input  src_en, tape_out, midi_out, uart_out, drop_clr,
      output uart_tx, owner, busy, drop_cnt
   );
endinterface

// File: rtl/tx_src_edge.sv
// rtl/tx_src_edge.sv - per-source previous-level register and enable-gated edge detect
module tx_src_edge (
   input  logic clk_i,
   input  logic rst_i,
   input  logic level_i,
   input  logic en_i,
   output logic edge_o,
   output logic level_o
);
   logic prev_q;

   // Tracks the level even while disabled so re-enabling never fakes an edge.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) prev_q <= 1'b1;
      else       prev_q <= level_i;
   end

   assign edge_o  = en_i & (level_i ^ prev_q);
   assign level_o = level_i;
endmodule

// File: rtl/tx_line_arbiter.sv
// rtl/tx_line_arbiter.sv - first-toggle-wins arbiter of tape/midi/uart onto one TX pin
module tx_line_arbiter
   import tx_arb_pkg::*;
#(
   parameter int HOLD_CYCLES = 84000,
   parameter int DROP_W      = 8
) (
   input  logic               clk_sys,
   input  logic               reset,
   tx_line_arbiter_if.slave   bus
);
   localparam int                 CNT_W    = $clog2(HOLD_CYCLES + 1);
   localparam logic [CNT_W-1:0]   CNT_TERM = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [DROP_W-1:0]  DROP_MAX = '1;
   localparam logic [NUM_SRC-1:0] ONE_HOT0 = {{(NUM_SRC-1){1'b0}}, 1'b1};

   logic [NUM_SRC-1:0] src_lvl, lvl, edg;
   assign src_lvl = {bus.uart_out, bus.midi_out, bus.tape_out};

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
      tx_src_edge u_edge (
         .clk_i   (clk_sys),
         .rst_i   (reset),
         .level_i (src_lvl[i]),
         .en_i    (bus.src_en[i]),
         .edge_o  (edg[i]),
         .level_o (lvl[i])
      );
   end

   state_t             state_q, state_d;
   owner_t             owner_q, owner_d;
   logic               tx_q, tx_d;
   logic               busy_q;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [NUM_SRC-1:0] drop_inc;
   logic [DROP_W-1:0]  drop_q [NUM_SRC];
   logic [1:0]         win_idx, own_idx;

   assign win_idx = edg[SRC_UART] ? SRC_UART : (edg[SRC_MIDI] ? SRC_MIDI : SRC_TAPE);
   assign own_idx = src_of(owner_q);

   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      tx_d     = tx_q;
      cnt_d    = cnt_q;
      drop_inc = '0;
      case (state_q)
         S_IDLE: begin
            if (|edg) begin
               state_d  = S_OWN;
               owner_d  = owner_of(win_idx);
               tx_d     = lvl[win_idx];
               cnt_d    = '0;
               drop_inc = edg & ~(ONE_HOT0 << win_idx);
            end
         end
         S_OWN: begin
            drop_inc = edg & ~(ONE_HOT0 << own_idx);
            if (!bus.src_en[own_idx] ||
                (!edg[own_idx] && cnt_q == CNT_TERM && lvl[own_idx])) begin
               state_d = S_IDLE;
               owner_d = OWN_NONE;
               tx_d    = 1'b1;
               cnt_d   = '0;
            end else if (edg[own_idx]) begin
               tx_d  = lvl[own_idx];
               cnt_d = '0;
            end else if (cnt_q != CNT_TERM) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         owner_q <= OWN_NONE;
         tx_q    <= 1'b1;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         tx_q    <= tx_d;
         cnt_q   <= cnt_d;
         busy_q  <= (state_d == S_OWN);
      end
   end

   // Clear beats a same-cycle increment.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_SRC; i++) drop_q[i] <= '0;
      end else if (bus.drop_clr) begin
         for (int i = 0; i < NUM_SRC; i++) drop_q[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_SRC; i++)
            if (drop_inc[i] && drop_q[i] != DROP_MAX) drop_q[i] <= drop_q[i] + 1'b1;
      end
   end

   assign bus.uart_tx  = tx_q;
   assign bus.owner    = owner_q;
   assign bus.busy     = busy_q;
   assign bus.drop_cnt = {drop_q[SRC_UART], drop_q[SRC_MIDI], drop_q[SRC_TAPE]};
endmodule
